// File: rtl/shake256_squeeze_serializer.sv
// shake256_squeeze_serializer: buffers up to two SHAKE256 rate blocks and streams the requested
// number of output bits as MSB-first OUT_W-bit words over valid/ready.
module shake256_squeeze_serializer #(
   parameter int OUT_W = 64,
   parameter int RATE  = 1088
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [15:0]      out_bits,
   input  logic             squeezed,
   input  logic [RATE-1:0]  hash,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             done,
   output logic             stall,
   output logic             overflow
);
   localparam int NW = RATE / OUT_W;
   localparam int KW = $clog2(NW);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [RATE-1:0]  slot_q [2];
   logic [RATE-1:0]  slot_d [2];
   logic [1:0]       full_q, full_d;
   logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [KW-1:0]    k_q, k_d;
   logic [15:0]      remaining_q, remaining_d;
   logic             overflow_q, overflow_d;
   logic             sq_prev_q, sq_prev_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;
   logic             xfer, sq_edge;
   logic [15:0]      take;
   logic [RATE-1:0]  rd_blk;
   logic [OUT_W-1:0] word;

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      full_d      = full_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      k_d         = k_q;
      remaining_d = remaining_q;
      overflow_d  = overflow_q;
      sq_prev_d   = squeezed;
      sq_edge     = squeezed && !sq_prev_q;
      xfer        = out_valid_q && out_ready;
      take        = (remaining_q > 16'(OUT_W)) ? 16'(OUT_W) : remaining_q;
      if (state_q == IDLE) begin
         if (start) begin
            remaining_d = out_bits;
            overflow_d  = 1'b0;
            full_d      = '0;
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            k_d         = '0;
            state_d     = (out_bits == 16'd0) ? DONE : RUN;
         end
      end else if (state_q == RUN) begin
         if (xfer) begin
            remaining_d = remaining_q - take;
            if (out_last_q) begin
               state_d = DONE;
               full_d  = '0;
            end else if (k_q == KW'(NW - 1)) begin
               k_d              = '0;
               full_d[rd_ptr_q] = 1'b0;
               rd_ptr_d         = ~rd_ptr_q;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         // full_d already reflects a slot freed by this cycle's transfer
         if (sq_edge && !(xfer && out_last_q)) begin
            if (!full_d[wr_ptr_q]) begin
               slot_d[wr_ptr_q] = hash;
               full_d[wr_ptr_q] = 1'b1;
               wr_ptr_d         = ~wr_ptr_q;
            end else begin
               overflow_d = 1'b1;
            end
         end
      end else begin
         state_d = IDLE;
      end
      rd_blk      = slot_d[rd_ptr_d];
      word        = rd_blk[RATE-1-int'(k_d)*OUT_W -: OUT_W];
      out_valid_d = (state_d == RUN) && full_d[rd_ptr_d] && (remaining_d != 16'd0);
      out_last_d  = out_valid_d && (remaining_d <= 16'(OUT_W));
      // shifting by >= OUT_W yields a full mask, so only the final word is trimmed
      out_data_d  = out_valid_d ? (word & ~({OUT_W{1'b1}} >> remaining_d)) : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         full_q      <= '0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         k_q         <= '0;
         remaining_q <= '0;
         overflow_q  <= 1'b0;
         sq_prev_q   <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         full_q      <= full_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         k_q         <= k_d;
         remaining_q <= remaining_d;
         overflow_q  <= overflow_d;
         sq_prev_q   <= sq_prev_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   always_ff @(posedge clock) begin
      slot_q <= slot_d;
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign done      = (state_q == DONE);
   assign stall     = &full_q;
   assign overflow  = overflow_q;
endmodule

// File: tb/tb_shake256_squeeze_serializer.sv
// tb_shake256_squeeze_serializer: directed streams checked against a queue of expected words
// filled when blocks are squeezed and drained as the serializer transfers.
module tb_shake256_squeeze_serializer;
   logic          clock = 1'b0, reset = 1'b1, start = 1'b0, squeezed = 1'b0, out_ready = 1'b0;
   logic [15:0]   out_bits = '0;
   logic [1087:0] hash = '0;
   logic [63:0]   out_data;
   logic          out_valid, out_last, done, stall, overflow;

   int            vectors = 0, miscompares = 0, xfers = 0, exp_rem = 0, n = 0;
   logic [64:0]   sb [$];
   logic          held = 1'b0;
   logic [63:0]   held_d = '0;
   logic [1087:0] b1, b2, b3;

   always #5 clock = ~clock;

   shake256_squeeze_serializer dut (
      .clock(clock), .reset(reset), .start(start), .out_bits(out_bits),
      .squeezed(squeezed), .hash(hash), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_last(out_last), .done(done), .stall(stall),
      .overflow(overflow)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic go(input int bits);
      out_bits = 16'(bits);
      start = 1'b1;
      step();
      start = 1'b0;
      exp_rem = bits;
   endtask

   task automatic sqz(input logic [1087:0] b);
      hash = b;
      squeezed = 1'b1;
      step();
      squeezed = 1'b0;
   endtask

   task automatic push_w(input logic [63:0] w, input logic last);
      sb.push_back({last, w});
   endtask

   // expected words of a block, keeping only the top exp_rem bits of the last one
   task automatic push_blk(input logic [1087:0] b);
      logic [63:0] w;
      for (int k = 0; k < 17 && exp_rem > 0; k++) begin
         w = b[1087-64*k -: 64];
         if (exp_rem < 64) w = (w >> (64 - exp_rem)) << (64 - exp_rem);
         sb.push_back({(exp_rem <= 64), w});
         exp_rem -= (exp_rem > 64) ? 64 : exp_rem;
      end
   endtask

   task automatic wait_done(input int budget, input logic toggle);
      int c = 0;
      while (done !== 1'b1 && c < budget) begin
         if (toggle) out_ready = ~out_ready;
         step();
         c++;
      end
      chk("done_seen", 64'(done), 64'd1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_data"}, out_data, 64'd0);
      chk({tag, "_valid"}, 64'(out_valid), 64'd0);
      chk({tag, "_last"}, 64'(out_last), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_stall"}, 64'(stall), 64'd0);
      chk({tag, "_overflow"}, 64'(overflow), 64'd0);
   endtask

   always @(negedge clock) begin
      logic [64:0] e;
      if (held && out_valid) chk("hold_stable", out_data, held_d);
      held = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
         xfers++;
         chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("word_data", out_data, e[63:0]);
            chk("word_last", 64'(out_last), 64'(e[64]));
         end
      end
   end

   initial begin
      b1 = {256'h46b9dd2b0ba88d13233b3feb743eeb243fcd52ea62b81b82b50c27646ed5762f,
            {13{64'h0123456789abcdef}}};
      for (int k = 0; k < 17; k++) begin
         b2[1087-64*k -: 64] = 64'hb2b2_0000_0000_0000 | 64'(k);
         b3[1087-64*k -: 64] = 64'hc3c3_0000_0000_0000 | 64'(k);
      end
      repeat (2) step();
      chk_idle_outputs("reset");
      reset = 1'b0;
      step();
      sqz(b3);
      step();
      chk("idle_sqz_valid", 64'(out_valid), 64'd0);
      chk("idle_sqz_stall", 64'(stall), 64'd0);
      chk("idle_sqz_ovf", 64'(overflow), 64'd0);

      out_ready = 1'b1;
      go(256);
      push_w(64'h46b9dd2b0ba88d13, 1'b0);
      push_w(64'h233b3feb743eeb24, 1'b0);
      push_w(64'h3fcd52ea62b81b82, 1'b0);
      push_w(64'hb50c27646ed5762f, 1'b1);
      n = xfers;
      sqz(b1);
      repeat (4) step();
      chk("basic_xfers", 64'(xfers - n), 64'd4);
      chk("basic_done", 64'(done), 64'd1);
      step();
      chk("basic_done_pulse", 64'(done), 64'd0);

      go(100);
      push_w(64'h46b9dd2b0ba88d13, 1'b0);
      push_w(64'h233b3feb70000000, 1'b1);
      sqz(b1);
      wait_done(10, 1'b0);
      step();

      out_ready = 1'b0;
      go(2176);
      sqz(b1);
      step();
      sqz(b2);
      chk("two_stall", 64'(stall), 64'd1);
      chk("two_ovf", 64'(overflow), 64'd0);
      push_blk(b1);
      push_blk(b2);
      n = xfers;
      out_ready = 1'b1;
      repeat (34) step();
      chk("two_xfers", 64'(xfers - n), 64'd34);
      chk("two_done", 64'(done), 64'd1);
      chk("two_ovf_end", 64'(overflow), 64'd0);
      chk("two_sb_empty", 64'(sb.size()), 64'd0);
      step();

      out_ready = 1'b0;
      go(2176);
      sqz(b1);
      step();
      sqz(b2);
      step();
      chk("ovf_before", 64'(overflow), 64'd0);
      sqz(b3);
      chk("ovf_set", 64'(overflow), 64'd1);
      repeat (3) step();
      chk("ovf_sticky", 64'(overflow), 64'd1);
      push_blk(b1);
      push_blk(b2);
      n = xfers;
      out_ready = 1'b1;
      repeat (34) step();
      chk("ovf_xfers", 64'(xfers - n), 64'd34);
      chk("ovf_done", 64'(done), 64'd1);
      chk("ovf_still_set", 64'(overflow), 64'd1);
      step();

      out_ready = 1'b0;
      go(256);
      chk("ovf_cleared", 64'(overflow), 64'd0);
      push_w(64'h46b9dd2b0ba88d13, 1'b0);
      push_w(64'h233b3feb743eeb24, 1'b0);
      push_w(64'h3fcd52ea62b81b82, 1'b0);
      push_w(64'hb50c27646ed5762f, 1'b1);
      sqz(b1);
      wait_done(40, 1'b1);
      step();

      out_ready = 1'b1;
      go(256);
      push_w(64'h46b9dd2b0ba88d13, 1'b0);
      push_w(64'h233b3feb743eeb24, 1'b0);
      sqz(b1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk_idle_outputs("midreset");
      sb.delete();
      go(256);
      push_w(64'h46b9dd2b0ba88d13, 1'b0);
      push_w(64'h233b3feb743eeb24, 1'b0);
      push_w(64'h3fcd52ea62b81b82, 1'b0);
      push_w(64'hb50c27646ed5762f, 1'b1);
      sqz(b1);
      wait_done(10, 1'b0);
      step();

      go(0);
      chk("empty_done", 64'(done), 64'd1);
      chk("empty_valid", 64'(out_valid), 64'd0);
      step();
      chk("empty_done_off", 64'(done), 64'd0);
      chk("empty_valid_off", 64'(out_valid), 64'd0);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
